cla_32_bit_subtractor_pipe: RTL and testbench

- Pipelined 32-bit subtractor with block borrow-lookahead. It computes D = A - B - Bin and the flags Bout, V and Z.
- It is the inverse-operation companion to the team's registered 32-bit carry-lookahead adder. It sits in the same datapath lab as the decrement/compare unit feeding the ALU result mux.
- Adds a valid/ready handshake on both sides. The sum is split across two pipeline stages (low half, then high half) to halve the lookahead depth per cycle.

---
 rtl/cla_32_bit_subtractor_pipe_pkg.sv | 8 +
 rtl/bla_4_bit_subtractor.sv | 42 ++++
 rtl/cla_32_bit_subtractor_pipe.sv | 145 ++++++++++++++
 tb/tb_cla_32_bit_subtractor_pipe.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_32_bit_subtractor_pipe_pkg.sv
// Shared constants for the pipelined borrow-lookahead subtractor.
// Benches use STAGES as the input-to-output latency in clock edges.
package cla_32_bit_subtractor_pipe_pkg;
    localparam int unsigned WIDTH  = 32;
    localparam int unsigned BLK    = 4;
    localparam int unsigned NBLK   = WIDTH / BLK;
    localparam int unsigned STAGES = 3;
endpackage

// File: rtl/bla_4_bit_subtractor.sv
// One borrow-lookahead block: per-bit difference plus block propagate/generate of borrow.
// P/G are kept in a separate process from the difference so they never depend on bin_i.
module bla_4_bit_subtractor
    import cla_32_bit_subtractor_pipe_pkg::*;
#(
    parameter int unsigned Blk = BLK
) (
    input  logic [Blk-1:0] a_i,
    input  logic [Blk-1:0] b_i,
    input  logic           bin_i,
    output logic [Blk-1:0] d_o,
    output logic           p_o,
    output logic           g_o
);

    logic [Blk-1:0] p;
    logic [Blk-1:0] g;
    logic           g_acc;
    logic           br;

    assign p = ~(a_i ^ b_i);
    assign g = ~a_i & b_i;

    always_comb begin
        g_acc = 1'b0;
        for (int i = 0; i < Blk; i++) begin
            g_acc = g[i] | (p[i] & g_acc);
        end
        p_o = &p;
        g_o = g_acc;
    end

    always_comb begin
        br  = bin_i;
        d_o = '0;
        for (int i = 0; i < Blk; i++) begin
            d_o[i] = a_i[i] ^ b_i[i] ^ br;
            br     = g[i] | (p[i] & br);
        end
    end

endmodule

// File: rtl/cla_32_bit_subtractor_pipe.sv
// Three-stage elastic subtractor D = A - B - Bin: input register, low half, high half + flags.
// Each half chains its blocks with lookahead; the mid borrow is registered between halves.
module cla_32_bit_subtractor_pipe
    import cla_32_bit_subtractor_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = cla_32_bit_subtractor_pipe_pkg::WIDTH,
    parameter int unsigned BLK   = cla_32_bit_subtractor_pipe_pkg::BLK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] D_reg,
    output logic             Bout_reg,
    output logic             V_reg,
    output logic             Z_reg,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned HALF  = WIDTH / 2;
    localparam int unsigned NHALF = (WIDTH / BLK) / 2;

    // Stage registers
    logic             s1_valid_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             bin_q;
    logic             s2_valid_q;
    logic [HALF-1:0]  d_lo_q;
    logic [HALF-1:0]  a_hi_q;
    logic [HALF-1:0]  b_hi_q;
    logic             b_mid_q;

    logic adv1, adv2, adv3;

    assign adv3     = !out_valid || out_ready;
    assign adv2     = !s2_valid_q || adv3;
    assign adv1     = !s1_valid_q || adv2;
    assign in_ready = adv1;

    // Low half
    logic [NHALF-1:0] lo_p, lo_g, lo_bin;
    logic [HALF-1:0]  lo_d;
    logic             lo_bout;

    for (genvar k = 0; k < NHALF; k++) begin : g_lo
        bla_4_bit_subtractor #(
            .Blk (BLK)
        ) u_blk (
            .a_i   (a_q[k*BLK +: BLK]),
            .b_i   (b_q[k*BLK +: BLK]),
            .bin_i (lo_bin[k]),
            .d_o   (lo_d[k*BLK +: BLK]),
            .p_o   (lo_p[k]),
            .g_o   (lo_g[k])
        );
    end

    always_comb begin
        lo_bout = bin_q;
        lo_bin  = '0;
        for (int k = 0; k < NHALF; k++) begin
            lo_bin[k] = lo_bout;
            lo_bout   = lo_g[k] | (lo_p[k] & lo_bout);
        end
    end

    // High half
    logic [NHALF-1:0] hi_p, hi_g, hi_bin;
    logic [HALF-1:0]  hi_d;
    logic             hi_bout;

    for (genvar k = 0; k < NHALF; k++) begin : g_hi
        bla_4_bit_subtractor #(
            .Blk (BLK)
        ) u_blk (
            .a_i   (a_hi_q[k*BLK +: BLK]),
            .b_i   (b_hi_q[k*BLK +: BLK]),
            .bin_i (hi_bin[k]),
            .d_o   (hi_d[k*BLK +: BLK]),
            .p_o   (hi_p[k]),
            .g_o   (hi_g[k])
        );
    end

    always_comb begin
        hi_bout = b_mid_q;
        hi_bin  = '0;
        for (int k = 0; k < NHALF; k++) begin
            hi_bin[k] = hi_bout;
            hi_bout   = hi_g[k] | (hi_p[k] & hi_bout);
        end
    end

    logic [WIDTH-1:0] d_full;
    logic             v_d;

    assign d_full = {hi_d, d_lo_q};
    assign v_d    = (a_hi_q[HALF-1] != b_hi_q[HALF-1]) & (hi_d[HALF-1] != a_hi_q[HALF-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            bin_q      <= 1'b0;
            s2_valid_q <= 1'b0;
            d_lo_q     <= '0;
            a_hi_q     <= '0;
            b_hi_q     <= '0;
            b_mid_q    <= 1'b0;
            out_valid  <= 1'b0;
            D_reg      <= '0;
            Bout_reg   <= 1'b0;
            V_reg      <= 1'b0;
            Z_reg      <= 1'b0;
        end else begin
            if (adv1) s1_valid_q <= in_valid;
            if (in_valid && adv1) begin
                a_q   <= A;
                b_q   <= B;
                bin_q <= Bin;
            end
            if (adv2) s2_valid_q <= s1_valid_q;
            if (s1_valid_q && adv2) begin
                d_lo_q  <= lo_d;
                a_hi_q  <= a_q[WIDTH-1:HALF];
                b_hi_q  <= b_q[WIDTH-1:HALF];
                b_mid_q <= lo_bout;
            end
            if (adv3) out_valid <= s2_valid_q;
            if (s2_valid_q && adv3) begin
                D_reg    <= d_full;
                Bout_reg <= hi_bout;
                V_reg    <= v_d;
                Z_reg    <= ~|d_full;
            end
        end
    end

endmodule

// File: tb/tb_cla_32_bit_subtractor_pipe.sv
// Self-checking bench: directed corner cases, random items, stalled back-to-back stream
// and asynchronous mid-stream reset, all against an arithmetic reference model.
module tb_cla_32_bit_subtractor_pipe;
    import cla_32_bit_subtractor_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] A, B;
    logic        Bin;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] D_reg;
    logic        Bout_reg, V_reg, Z_reg;
    logic        out_valid;
    logic        out_ready;

    int checks   = 0;
    int failures = 0;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    always #5 clk = ~clk;

    cla_32_bit_subtractor_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .D_reg     (D_reg),
        .Bout_reg  (Bout_reg),
        .V_reg     (V_reg),
        .Z_reg     (Z_reg),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Plain integer arithmetic: unsigned for D/Bout, signed range test for V.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic bin,
                                  output logic [31:0] d, output logic bout, output logic v,
                                  output logic z);
        longint ua, ub, lb, diff, sa, sb, sd;
        ua   = {32'b0, a};
        ub   = {32'b0, b};
        lb   = longint'(bin);
        diff = ua - ub - lb;
        d    = diff[31:0];
        bout = (diff < 0);
        sa   = $signed(a);
        sb   = $signed(b);
        sd   = sa - sb - lb;
        v    = (sd > SMAX) || (sd < SMIN);
        z    = (d == 32'h0);
    endfunction

    // Pushes one item into an idle pipe and waits (bounded) for its result.
    task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic bin,
                           output logic [31:0] d, output logic bout, output logic v,
                           output logic z, output int lat);
        @(negedge clk);
        A = a; B = b; Bin = bin; in_valid = 1'b1; out_ready = 1'b1;
        lat = -1; d = '0; bout = 1'b0; v = 1'b0; z = 1'b0;
        @(posedge clk);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                lat = i; d = D_reg; bout = Bout_reg; v = V_reg; z = Z_reg;
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Bin = 1'b0;
        #22;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, D_reg, Bout_reg, V_reg, Z_reg} !== 36'h0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%0b D=%h B=%0b V=%0b Z=%0b, want all 0",
                     out_valid, D_reg, Bout_reg, V_reg, Z_reg);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %0b want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [31:0] ta [6] = '{32'h5, 32'h0, 32'h80000000, 32'h12345678, 32'h12345678,
                                32'h00010000};
        logic [31:0] tb [6] = '{32'h3, 32'h1, 32'h1, 32'h12345678, 32'h12345678, 32'h1};
        logic        tn [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] ed [6] = '{32'h2, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h0, 32'hFFFFFFFF,
                                32'h0000FFFF};
        logic        eb [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        ev [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        ez [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] d;
        logic        bo, v, z;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            run_one(ta[i], tb[i], tn[i], d, bo, v, z, lat);
            checks++;
            if (lat != int'(STAGES)) begin
                failures++;
                $display("FAIL directed%0d_latency: got %0d want %0d", i, lat, STAGES);
            end
            checks++;
            if (d !== ed[i]) begin
                failures++;
                $display("FAIL directed%0d_D: got %h want %h", i, d, ed[i]);
            end
            checks++;
            if ({bo, v, z} !== {eb[i], ev[i], ez[i]}) begin
                failures++;
                $display("FAIL directed%0d_flags: got BVZ=%b want %b", i, {bo, v, z},
                         {eb[i], ev[i], ez[i]});
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, d, md;
        logic        bin, bo, v, z, mb, mv, mz;
        int          lat;
        for (int i = 0; i < 16; i++) begin
            a   = $urandom;
            b   = (i % 4 == 0) ? a : $urandom;
            bin = 1'($urandom_range(0, 1));
            model(a, b, bin, md, mb, mv, mz);
            run_one(a, b, bin, d, bo, v, z, lat);
            checks++;
            if (lat != int'(STAGES) || d !== md || {bo, v, z} !== {mb, mv, mz}) begin
                failures++;
                $display("FAIL random%0d: got lat=%0d D=%h BVZ=%b want lat=%0d D=%h BVZ=%b",
                         i, lat, d, {bo, v, z}, STAGES, md, {mb, mv, mz});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ia [10];
        logic [31:0] ib [10];
        logic        in_ [10];
        logic [31:0] md, prev_d;
        logic        mb, mv, mz, acc, stalled_prev;
        int          sent, got, inflight;
        bit          saw_full;
        for (int i = 0; i < 10; i++) begin
            ia[i] = $urandom; ib[i] = $urandom; in_[i] = 1'($urandom_range(0, 1));
        end
        sent = 0; got = 0; saw_full = 0; stalled_prev = 0; prev_d = '0;
        for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 4 && cyc <= 8);
            if (sent < 10) begin
                in_valid = 1'b1; A = ia[sent]; B = ib[sent]; Bin = in_[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            inflight = sent - got;
            if (!in_ready) saw_full = 1;
            checks++;
            if (in_ready !== ((inflight < 3) || out_ready)) begin
                failures++;
                $display("FAIL b2b_in_ready cyc%0d: got %0b want %0b (inflight=%0d)", cyc,
                         in_ready, (inflight < 3) || out_ready, inflight);
            end
            if (stalled_prev) begin
                checks++;
                if (D_reg !== prev_d) begin
                    failures++;
                    $display("FAIL b2b_stall_hold cyc%0d: got %h want %h", cyc, D_reg, prev_d);
                end
            end
            if (out_valid && out_ready) begin
                model(ia[got], ib[got], in_[got], md, mb, mv, mz);
                checks++;
                if (D_reg !== md || {Bout_reg, V_reg, Z_reg} !== {mb, mv, mz}) begin
                    failures++;
                    $display("FAIL b2b_item%0d: got D=%h BVZ=%b want D=%h BVZ=%b", got, D_reg,
                             {Bout_reg, V_reg, Z_reg}, md, {mb, mv, mz});
                end
                got++;
            end
            acc          = in_valid && in_ready;
            stalled_prev = out_valid && !out_ready;
            prev_d       = D_reg;
            @(posedge clk);
            if (acc) sent++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (got != 10) begin
            failures++;
            $display("FAIL b2b_count: got %0d results want 10", got);
        end
        checks++;
        if (!saw_full) begin
            failures++;
            $display("FAIL b2b_backpressure: got in_ready never low want low when 3 held");
        end
    endtask

    task automatic test_reset_midstream();
        bit stale;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; A = 32'd9; B = 32'd2; Bin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        A = 32'd100; B = 32'd1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || D_reg !== 32'd7) begin
            failures++;
            $display("FAIL midrst_pre: got valid=%0b D=%h want valid=1 D=00000007",
                     out_valid, D_reg);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, D_reg, Bout_reg, V_reg, Z_reg} !== 36'h0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_clear: got valid=%0b D=%h BVZ=%b rdy=%0b want 0/0/000/1",
                     out_valid, D_reg, {Bout_reg, V_reg, Z_reg}, in_ready);
        end
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) stale = 1;
        end
        checks++;
        if (stale) begin
            failures++;
            $display("FAIL midrst_stale: got out_valid=1 after reset want 0");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
